fetch_decode: RTL and testbench

Instruction-fetch and decode stage of the multi-cycle RV32I core, directly upstream of the control unit.
- Holds PC, PC0 (address of the current instruction) and IR.
- Drives the instruction-memory address.
- Decodes IR into the one-hot instruction class flags and the 4-bit ALU_OP the control unit consumes.
- Consumes the control unit's PC_Write/PC0_Write/IR_Write/PC_s to update its registers, and produces the immediate and register indices for the datapath.

---
 rtl/fetch_decode.sv | 127 ++++++++++++
 tb/tb_fetch_decode.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode.sv
// Fetch/decode stage of the multi-cycle RV32I core: holds pc/pc0/ir and decodes ir for the control unit.
// Optional macro ILLEGAL_DETECT_EN builds the sticky illegal-instruction detector.
module fetch_decode #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PC_Write,
    input  logic              PC0_Write,
    input  logic              IR_Write,
    input  logic [1:0]        PC_s,
    input  logic [31:0]       alu_f,
    input  logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       pc,
    output logic [31:0]       pc0,
    output logic [31:0]       ir,
    output logic [4:0]        rs1,
    output logic [4:0]        rs2,
    output logic [4:0]        rd,
    output logic [31:0]       imm,
    output logic              IS_R,
    output logic              IS_IMM,
    output logic              IS_LUI,
    output logic              IS_LW,
    output logic              IS_SW,
    output logic              IS_BEQ,
    output logic              IS_JAL,
    output logic              IS_JALR,
    output logic [3:0]        ALU_OP,
    output logic              illegal
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    // Class flags packed as {R, IMM, LUI, LW, SW, BEQ, JAL, JALR}; zero for anything unrecognised.
    function automatic logic [7:0] decode_class(input logic [31:0] i);
        logic [7:0] c;
        c = 8'b0;
        case (i[6:0])
            OP_R:    c = 8'b1000_0000;
            OP_IMM:  c = 8'b0100_0000;
            OP_LUI:  c = 8'b0010_0000;
            OP_LW:   c = (i[14:12] == 3'b010) ? 8'b0001_0000 : 8'b0;
            OP_SW:   c = (i[14:12] == 3'b010) ? 8'b0000_1000 : 8'b0;
            OP_BEQ:  c = (i[14:12] == 3'b000) ? 8'b0000_0100 : 8'b0;
            OP_JAL:  c = 8'b0000_0010;
            OP_JALR: c = (i[14:12] == 3'b000) ? 8'b0000_0001 : 8'b0;
            default: c = 8'b0;
        endcase
        return c;
    endfunction

    logic [31:0] next_pc;
    logic [7:0]  cls;

    always_comb begin
        next_pc = pc;
        case (PC_s)
            2'b00:   next_pc = pc + 32'd4;
            2'b01:   next_pc = pc0 + imm;
            2'b10:   next_pc = alu_f & ~32'd1;
            default: next_pc = pc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= RESET_PC;
            pc0 <= 32'h0000_0000;
            ir  <= 32'h0000_0013;
        end else begin
            if (PC_Write)  pc  <= next_pc;
            if (PC0_Write) pc0 <= pc;
            if (IR_Write)  ir  <= inst_data;
        end
    end

    assign inst_addr = pc[ADDR_W+1:2];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign rd        = ir[11:7];

    assign cls = decode_class(ir);
    assign {IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JAL, IS_JALR} = cls;

    always_comb begin
        ALU_OP = 4'b0000;
        if (IS_R)
            ALU_OP = {ir[30], ir[14:12]};
        else if (IS_IMM)
            ALU_OP = (ir[14:12] == 3'b101) ? {ir[30], ir[14:12]} : {1'b0, ir[14:12]};
    end

    // Immediate format follows the opcode alone, independent of funct3 legality.
    always_comb begin
        imm = 32'h0000_0000;
        case (ir[6:0])
            OP_IMM, OP_LW, OP_JALR: imm = {{20{ir[31]}}, ir[31:20]};
            OP_SW:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BEQ:  imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_LUI:  imm = {ir[31:12], 12'b0};
            OP_JAL:  imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm = 32'h0000_0000;
        endcase
    end

`ifdef ILLEGAL_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            illegal <= 1'b0;
        else if (IR_Write && (decode_class(inst_data) == 8'b0))
            illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboarded bench for fetch_decode: a driver pushes model-predicted state per cycle, a monitor pops and compares.
module tb_fetch_decode;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PC_Write = 0, PC0_Write = 0, IR_Write = 0;
    logic [1:0]  PC_s = 2'b00;
    logic [31:0] alu_f = 0, inst_data = 0;
    logic [5:0]  inst_addr;
    logic [31:0] pc, pc0, ir, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JAL, IS_JALR;
    logic [3:0]  ALU_OP;
    logic        illegal;

    fetch_decode #(.RESET_PC(RST_PC), .ADDR_W(6)) dut (
        .clk(clk), .rst(rst), .PC_Write(PC_Write), .PC0_Write(PC0_Write), .IR_Write(IR_Write),
        .PC_s(PC_s), .alu_f(alu_f), .inst_data(inst_data), .inst_addr(inst_addr),
        .pc(pc), .pc0(pc0), .ir(ir), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
        .IS_R(IS_R), .IS_IMM(IS_IMM), .IS_LUI(IS_LUI), .IS_LW(IS_LW), .IS_SW(IS_SW),
        .IS_BEQ(IS_BEQ), .IS_JAL(IS_JAL), .IS_JALR(IS_JALR), .ALU_OP(ALU_OP), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, pc0, ir, imm;
        logic [5:0]  addr;
        logic [7:0]  flags;
        logic [3:0]  alu_op;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    bit   drv_done = 0;

    // Reference state
    logic [31:0] m_pc, m_pc0, m_ir;
    logic        m_ill;

    typedef enum int {C_NONE, C_R, C_IMM, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_JALR} cls_e;

    function automatic cls_e classify(input logic [31:0] i);
        int op, f3;
        op = int'(i[6:0]);
        f3 = int'(i[14:12]);
        if (op == 'h33) return C_R;
        if (op == 'h13) return C_IMM;
        if (op == 'h37) return C_LUI;
        if (op == 'h03 && f3 == 2) return C_LW;
        if (op == 'h23 && f3 == 2) return C_SW;
        if (op == 'h63 && f3 == 0) return C_BEQ;
        if (op == 'h6f) return C_JAL;
        if (op == 'h67 && f3 == 0) return C_JALR;
        return C_NONE;
    endfunction

    function automatic logic [7:0] flags_of(input cls_e c);
        // bit 7 = IS_R down to bit 0 = IS_JALR
        if (c == C_NONE) return 8'h00;
        return 8'h01 << (int'(C_JALR) - int'(c));
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] i);
        int v;
        int op;
        op = int'(i[6:0]);
        v = 0;
        if (op == 'h13 || op == 'h03 || op == 'h67) v = $signed(i[31:20]);
        else if (op == 'h23) v = $signed({i[31:25], i[11:7]});
        else if (op == 'h63) begin v = $signed({i[31], i[7], i[30:25], i[11:8]}); v = v * 2; end
        else if (op == 'h37) v = int'(i[31:12]) * 4096;
        else if (op == 'h6f) begin v = $signed({i[31], i[19:12], i[20], i[30:21]}); v = v * 2; end
        return v;
    endfunction

    function automatic logic [3:0] aluop_of(input logic [31:0] i);
        cls_e c;
        c = classify(i);
        if (c == C_R) return {i[30], i[14:12]};
        if (c == C_IMM) return (i[14:12] == 3'd5) ? {i[30], i[14:12]} : {1'b0, i[14:12]};
        return 4'd0;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.pc = m_pc; e.pc0 = m_pc0; e.ir = m_ir;
        e.addr = m_pc[7:2];
        e.flags = flags_of(classify(m_ir));
        e.imm = imm_of(m_ir);
        e.alu_op = aluop_of(m_ir);
        e.rs1 = m_ir[19:15]; e.rs2 = m_ir[24:20]; e.rd = m_ir[11:7];
        e.ill = m_ill;
        return e;
    endfunction

    task automatic step(input bit r, input bit pw, input bit p0w, input bit irw,
                        input logic [1:0] ps, input logic [31:0] af, input logic [31:0] data);
        logic [31:0] npc;
        @(negedge clk);
        rst = r; PC_Write = pw; PC0_Write = p0w; IR_Write = irw; PC_s = ps; alu_f = af; inst_data = data;
        if (r) begin
            m_pc = RST_PC; m_pc0 = 0; m_ir = 32'h13; m_ill = 0;
        end else begin
            case (ps)
                2'd0: npc = m_pc + 4;
                2'd1: npc = m_pc0 + imm_of(m_ir);
                2'd2: npc = {af[31:1], 1'b0};
                default: npc = m_pc;
            endcase
`ifdef ILLEGAL_DETECT_EN
            if (irw && classify(data) == C_NONE) m_ill = 1;
`endif
            if (p0w) m_pc0 = m_pc;
            if (pw)  m_pc = npc;
            if (irw) m_ir = data;
        end
        q.push_back(snapshot());
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc", pc, e.pc);
                chk("pc0", pc0, e.pc0);
                chk("ir", ir, e.ir);
                chk("inst_addr", 32'(inst_addr), 32'(e.addr));
                chk("flags", 32'({IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JAL, IS_JALR}), 32'(e.flags));
                chk("imm", imm, e.imm);
                chk("alu_op", 32'(ALU_OP), 32'(e.alu_op));
                chk("regs", 32'({rs1, rs2, rd}), 32'({e.rs1, e.rs2, e.rd}));
                chk("illegal", 32'(illegal), 32'(e.ill));
            end
        end
    end

    function automatic logic [31:0] rand_inst();
        logic [31:0] i;
        logic [6:0]  ops [10];
        ops = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h17, 7'h7f};
        i = $urandom;
        i[6:0] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 2) != 0) begin
            if (i[6:0] == 7'h03 || i[6:0] == 7'h23) i[14:12] = 3'd2;
            if (i[6:0] == 7'h63 || i[6:0] == 7'h67) i[14:12] = 3'd0;
        end
        return i;
    endfunction

    initial begin
        step(1, 0, 0, 0, 2'd0, 0, 0);
        step(0, 1, 1, 1, 2'd0, 0, 32'h0050_0093);     // addi x1,x0,5
        step(1, 0, 0, 0, 2'd0, 0, 0);
        step(0, 1, 1, 1, 2'd0, 0, 32'h0080_006F);     // jal x0,+8
        step(0, 1, 0, 0, 2'd1, 0, 0);
        step(0, 1, 1, 1, 2'd0, 0, 32'hFE00_0EE3);     // beq x0,x0,-4
        step(0, 1, 0, 0, 2'd1, 0, 0);
        step(0, 1, 1, 1, 2'd0, 0, 32'h0000_80E7);     // jalr x1,0(x1)
        step(0, 1, 0, 0, 2'd2, 32'h0000_0103, 0);
        step(0, 1, 0, 0, 2'd3, 32'h0000_0103, 0);
        step(0, 0, 0, 1, 2'd0, 0, 32'hFFFF_FFFF);
        step(0, 1, 1, 1, 2'd0, 0, 32'h0050_0093);
        step(0, 0, 0, 0, 2'd0, 0, 0);
        step(1, 0, 0, 0, 2'd0, 0, 0);
        step(0, 0, 0, 0, 2'd0, 0, 0);
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 2'($urandom), $urandom, rand_inst());
        @(negedge clk);
        @(negedge clk);
        drv_done = 1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain actual=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
